// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stack_ctrl
//  Purpose  : RPN instruction sequencer for a 4-entry hardware operand stack.
//             Accepts one instruction per cycle from the fetch unit, drives
//             the stack load/push/pop/d controls, tracks depth, records the
//             first error, and runs a bit-serial shift-add multiplier
//             (and, optionally, a restoring divider).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N         data width (must match the stack width)
//  Ports
//    clk       in   clock, rising edge
//    reset     in   synchronous active-high reset
//    op        in   [3:0]   offered opcode
//    imm       in   [N-1:0] immediate for PUSHI
//    valid     in   upstream offers op/imm
//    ready     out  controller accepts op/imm this cycle
//    qtop      in   [N-1:0] stack top entry
//    qnext     in   [N-1:0] stack second entry
//    load      out  stack: write d into top
//    push      out  stack: shift down
//    pop       out  stack: shift up
//    d         out  [N-1:0] stack write data
//    depth     out  [2:0]   valid stack entries (0..4)
//    busy      out  multi-cycle operation in progress
//    err       out  sticky error flag
//    err_code  out  [1:0]   first error: 1 underflow, 2 overflow,
//                           3 illegal opcode / divide by zero
//  Build option
//    STACK_CTRL_DIV_EN  when defined, opcodes A (DIV) and B (MOD) are
//                       implemented; otherwise they are illegal opcodes.
// ============================================================================
module stack_ctrl #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   op,
    input  logic [N-1:0] imm,
    input  logic         valid,
    output logic         ready,
    input  logic [N-1:0] qtop,
    input  logic [N-1:0] qnext,
    output logic         load,
    output logic         push,
    output logic         pop,
    output logic [N-1:0] d,
    output logic [2:0]   depth,
    output logic         busy,
    output logic         err,
    output logic [1:0]   err_code
);

    localparam logic [3:0] c_OP_NOP   = 4'h0;
    localparam logic [3:0] c_OP_PUSHI = 4'h1;
    localparam logic [3:0] c_OP_POP   = 4'h2;
    localparam logic [3:0] c_OP_DUP   = 4'h3;
    localparam logic [3:0] c_OP_ADD   = 4'h4;
    localparam logic [3:0] c_OP_SUB   = 4'h5;
    localparam logic [3:0] c_OP_MUL   = 4'h6;
    localparam logic [3:0] c_OP_AND   = 4'h7;
    localparam logic [3:0] c_OP_OR    = 4'h8;
    localparam logic [3:0] c_OP_XOR   = 4'h9;
`ifdef STACK_CTRL_DIV_EN
    localparam logic [3:0] c_OP_DIV   = 4'hA;
    localparam logic [3:0] c_OP_MOD   = 4'hB;
`endif

    localparam logic [1:0] c_ERR_UNDER = 2'd1;
    localparam logic [1:0] c_ERR_OVER  = 2'd2;
    localparam logic [1:0] c_ERR_ILL   = 2'd3;

    localparam int             CW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  c_CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_depth;
    logic [2:0]      w_depth_nxt;
    logic            r_err;
    logic [1:0]      r_err_code;
    logic [CW-1:0]   r_cnt;
    // Iterative datapath. Multiply: r_a = shifted multiplicand,
    // r_b = shifted multiplier, r_acc = partial product.
    // Divide: r_a = dividend shifting out / quotient shifting in,
    // r_b = divisor, r_acc = partial remainder.
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_acc;
    logic [N-1:0]    w_result;

    logic            w_fault;
    logic [1:0]      w_fault_code;
    logic            w_start;

`ifdef STACK_CTRL_DIV_EN
    logic            r_div_mode;
    logic            r_want_quot;
    logic [N:0]      w_rem_sh;
    logic [N-1:0]    w_rem_sub;
    logic            w_rem_ge;

    // Remainder is always below the divisor, so the shifted value fits in
    // N+1 bits and a successful subtraction always fits back into N bits.
    assign w_rem_sh  = {r_acc, r_a[N-1]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub = w_rem_sh[N-1:0] - r_b;
    assign w_result  = r_want_quot ? r_a : r_acc;
`else
    assign w_result  = r_acc;
`endif

    assign depth    = r_depth;
    assign err      = r_err;
    assign err_code = r_err_code;

    // ------------------------------------------------------------------
    // Next state, stack controls and fault detection
    // ------------------------------------------------------------------
    always_comb begin
        ready        = 1'b0;
        load         = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        d            = '0;
        busy         = 1'b0;
        w_state_nxt  = r_state;
        w_depth_nxt  = r_depth;
        w_fault      = 1'b0;
        w_fault_code = 2'd0;
        w_start      = 1'b0;

        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    ready = 1'b1;
                    if (valid) begin
                        case (op)
                            c_OP_NOP: ;
                            c_OP_PUSHI: begin
                                if (r_depth <= 3'd3) begin
                                    load        = 1'b1;
                                    push        = 1'b1;
                                    d           = imm;
                                    w_depth_nxt = r_depth + 3'd1;
                                end else begin
                                    w_fault      = 1'b1;
                                    w_fault_code = c_ERR_OVER;
                                end
                            end
                            c_OP_POP: begin
                                if (r_depth >= 3'd1) begin
                                    pop         = 1'b1;
                                    w_depth_nxt = r_depth - 3'd1;
                                end else begin
                                    w_fault      = 1'b1;
                                    w_fault_code = c_ERR_UNDER;
                                end
                            end
                            c_OP_DUP: begin
                                if (r_depth == 3'd0) begin
                                    w_fault      = 1'b1;
                                    w_fault_code = c_ERR_UNDER;
                                end else if (r_depth >= 3'd4) begin
                                    w_fault      = 1'b1;
                                    w_fault_code = c_ERR_OVER;
                                end else begin
                                    load        = 1'b1;
                                    push        = 1'b1;
                                    d           = qtop;
                                    w_depth_nxt = r_depth + 3'd1;
                                end
                            end
                            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR: begin
                                if (r_depth >= 3'd2) begin
                                    load        = 1'b1;
                                    pop         = 1'b1;
                                    w_depth_nxt = r_depth - 3'd1;
                                    case (op)
                                        c_OP_ADD: d = qnext + qtop;
                                        c_OP_SUB: d = qnext - qtop;
                                        c_OP_AND: d = qnext & qtop;
                                        c_OP_OR:  d = qnext | qtop;
                                        default:  d = qnext ^ qtop;
                                    endcase
                                end else begin
                                    w_fault      = 1'b1;
                                    w_fault_code = c_ERR_UNDER;
                                end
                            end
                            c_OP_MUL: begin
                                if (r_depth >= 3'd2) begin
                                    w_start     = 1'b1;
                                    w_state_nxt = ST_MUL;
                                end else begin
                                    w_fault      = 1'b1;
                                    w_fault_code = c_ERR_UNDER;
                                end
                            end
`ifdef STACK_CTRL_DIV_EN
                            // Depth is checked before the zero divisor,
                            // since qtop is meaningless below depth 2.
                            c_OP_DIV, c_OP_MOD: begin
                                if (r_depth < 3'd2) begin
                                    w_fault      = 1'b1;
                                    w_fault_code = c_ERR_UNDER;
                                end else if (qtop == '0) begin
                                    w_fault      = 1'b1;
                                    w_fault_code = c_ERR_ILL;
                                end else begin
                                    w_start     = 1'b1;
                                    w_state_nxt = ST_MUL;
                                end
                            end
`endif
                            default: begin
                                w_fault      = 1'b1;
                                w_fault_code = c_ERR_ILL;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    busy = 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = ST_WB;
                    end
                end
                ST_WB: begin
                    busy        = 1'b1;
                    load        = 1'b1;
                    pop         = 1'b1;
                    d           = w_result;
                    w_depth_nxt = r_depth - 3'd1;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_depth    <= 3'd0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_depth <= w_depth_nxt;
            if (w_fault) begin
                r_err <= 1'b1;
                // Only the first error is recorded.
                if (!r_err) begin
                    r_err_code <= w_fault_code;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Iterative multiply / divide datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
`ifdef STACK_CTRL_DIV_EN
            r_div_mode  <= 1'b0;
            r_want_quot <= 1'b0;
`endif
        end else if (w_start) begin
            r_cnt       <= '0;
            r_a         <= qnext;
            r_b         <= qtop;
            r_acc       <= '0;
`ifdef STACK_CTRL_DIV_EN
            r_div_mode  <= (op == c_OP_DIV) || (op == c_OP_MOD);
            r_want_quot <= (op == c_OP_DIV);
`endif
        end else if (r_state == ST_MUL) begin
            r_cnt <= r_cnt + CW'(1);
`ifdef STACK_CTRL_DIV_EN
            if (r_div_mode) begin
                if (w_rem_ge) begin
                    r_acc <= w_rem_sub;
                    r_a   <= {r_a[N-2:0], 1'b1};
                end else begin
                    r_acc <= w_rem_sh[N-1:0];
                    r_a   <= {r_a[N-2:0], 1'b0};
                end
            end else begin
                if (r_b[0]) begin
                    r_acc <= r_acc + r_a;
                end
                r_a <= r_a << 1;
                r_b <= r_b >> 1;
            end
`else
            if (r_b[0]) begin
                r_acc <= r_acc + r_a;
            end
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_ctrl
//  Purpose  : Directed self-checking bench for stack_ctrl. Includes a simple
//             4-entry stack that responds to load/push/pop and feeds
//             qtop/qnext back to the controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;

    localparam int N = 16;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_POP   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_MUL   = 4'h6;
    localparam logic [3:0] OP_DIV   = 4'hA;
    localparam logic [3:0] OP_MOD   = 4'hB;
    localparam logic [3:0] OP_ILL   = 4'hE;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   op;
    logic [N-1:0] imm;
    logic         valid;
    logic         ready;
    logic [N-1:0] qtop;
    logic [N-1:0] qnext;
    logic         load;
    logic         push;
    logic         pop;
    logic [N-1:0] d;
    logic [2:0]   depth;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] s0, s1, s2, s3;

    always #5 clk = ~clk;

    stack_ctrl #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .imm      (imm),
        .valid    (valid),
        .ready    (ready),
        .qtop     (qtop),
        .qnext    (qnext),
        .load     (load),
        .push     (push),
        .pop      (pop),
        .d        (d),
        .depth    (depth),
        .busy     (busy),
        .err      (err),
        .err_code (err_code)
    );

    // Operand stack driven by the controller.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0 <= '0; s1 <= '0; s2 <= '0; s3 <= '0;
        end else if (push) begin
            s0 <= load ? d : s0;
            s1 <= s0; s2 <= s1; s3 <= s2;
        end else if (pop) begin
            s0 <= load ? d : s1;
            s1 <= s2; s2 <= s3;
        end else if (load) begin
            s0 <= d;
        end
    end
    assign qtop  = s0;
    assign qnext = s1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one set of inputs for one cycle; outputs settle 1 time unit
    // after the falling edge and are checked before the next rising edge.
    task automatic cyc(input logic v, input logic [3:0] o, input logic [N-1:0] i);
        @(negedge clk);
        valid = v; op = o; imm = i;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; valid = 1'b0; op = OP_NOP; imm = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic ctl(input string tag, input logic l, input logic pu, input logic po);
        chk({tag, "_load"}, {31'd0, load}, {31'd0, l});
        chk({tag, "_push"}, {31'd0, push}, {31'd0, pu});
        chk({tag, "_pop"},  {31'd0, pop},  {31'd0, po});
    endtask

    // After a MUL/DIV/MOD accept: N busy cycles, then the write-back cycle.
    task automatic wait_iter(input string tag, input logic [N-1:0] exp_d);
        for (int k = 1; k <= N + 1; k++) begin
            cyc(1'b1, OP_PUSHI, 16'h0055);
            chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
            chk({tag, "_busy"},  {31'd0, busy},  32'd1);
            if (k <= N) begin
                ctl({tag, "_iter"}, 1'b0, 1'b0, 1'b0);
            end else begin
                ctl({tag, "_wb"}, 1'b1, 1'b0, 1'b1);
                chk({tag, "_wb_d"}, {16'd0, d}, {16'd0, exp_d});
            end
        end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b1; op = OP_PUSHI; imm = 16'h1234;

        // ---------------- reset state ----------------
        @(negedge clk); #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        ctl("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_d",     {16'd0, d}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_depth", {29'd0, depth}, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        chk("rst_code",  {30'd0, err_code}, 32'd0);
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;

        // ---------------- PUSHI 7, PUSHI 5, SUB back to back ----------------
        cyc(1'b1, OP_PUSHI, 16'd7);
        chk("sub_ready0", {31'd0, ready}, 32'd1);
        ctl("sub_push7", 1'b1, 1'b1, 1'b0);
        chk("sub_d7", {16'd0, d}, 32'd7);
        cyc(1'b1, OP_PUSHI, 16'd5);
        chk("sub_ready1", {31'd0, ready}, 32'd1);
        chk("sub_depth1", {29'd0, depth}, 32'd1);
        cyc(1'b1, OP_SUB, 16'd0);
        chk("sub_ready2", {31'd0, ready}, 32'd1);
        ctl("sub_op", 1'b1, 1'b0, 1'b1);
        chk("sub_d", {16'd0, d}, 32'd2);
        cyc(1'b0, OP_NOP, 16'd0);
        chk("sub_qtop",  {16'd0, qtop}, 32'd2);
        chk("sub_depth", {29'd0, depth}, 32'd1);
        chk("sub_err",   {31'd0, err}, 32'd0);

        // ---------------- ADD with wrap ----------------
        cyc(1'b1, OP_PUSHI, 16'hFFFF);
        cyc(1'b1, OP_PUSHI, 16'h0002);
        cyc(1'b1, OP_ADD, 16'd0);
        chk("add_d", {16'd0, d}, 32'h0001);
        cyc(1'b0, OP_NOP, 16'd0);
        chk("add_qtop",  {16'd0, qtop}, 32'h0001);
        chk("add_depth", {29'd0, depth}, 32'd2);

        // ---------------- MUL 3 * 4 ----------------
        do_reset();
        cyc(1'b1, OP_PUSHI, 16'h0003);
        cyc(1'b1, OP_PUSHI, 16'h0004);
        cyc(1'b1, OP_MUL, 16'd0);
        chk("mul_acc_ready", {31'd0, ready}, 32'd1);
        ctl("mul_acc", 1'b0, 1'b0, 1'b0);
        wait_iter("mul", 16'h000C);
        cyc(1'b1, OP_NOP, 16'd0);
        chk("mul_next_ready", {31'd0, ready}, 32'd1);
        chk("mul_next_busy",  {31'd0, busy}, 32'd0);
        chk("mul_depth", {29'd0, depth}, 32'd1);
        chk("mul_qtop",  {16'd0, qtop}, 32'h000C);

        // ---------------- overflow on fifth PUSHI ----------------
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, OP_PUSHI, 16'(i));
        end
        cyc(1'b1, OP_PUSHI, 16'd5);
        chk("ovf_ready", {31'd0, ready}, 32'd1);
        ctl("ovf", 1'b0, 1'b0, 1'b0);
        cyc(1'b1, OP_POP, 16'd0);
        chk("ovf_err",   {31'd0, err}, 32'd1);
        chk("ovf_code",  {30'd0, err_code}, 32'd2);
        chk("ovf_depth", {29'd0, depth}, 32'd4);
        ctl("ovf_pop", 1'b0, 1'b0, 1'b1);
        cyc(1'b1, OP_ADD, 16'd0);
        chk("ovf_depth3", {29'd0, depth}, 32'd3);
        ctl("ovf_add", 1'b1, 1'b0, 1'b1);
        chk("ovf_add_d", {16'd0, d}, 32'd5);
        cyc(1'b0, OP_NOP, 16'd0);
        chk("ovf_depth2", {29'd0, depth}, 32'd2);
        chk("ovf_code_kept", {30'd0, err_code}, 32'd2);

        // ---------------- underflow then illegal ----------------
        do_reset();
        cyc(1'b1, OP_POP, 16'd0);
        ctl("unf_pop", 1'b0, 1'b0, 1'b0);
        cyc(1'b1, OP_ILL, 16'd0);
        chk("unf_err1",  {31'd0, err}, 32'd1);
        chk("unf_code1", {30'd0, err_code}, 32'd1);
        ctl("unf_ill", 1'b0, 1'b0, 1'b0);
        cyc(1'b1, OP_PUSHI, 16'd9);
        chk("unf_code2", {30'd0, err_code}, 32'd1);
        chk("unf_depth", {29'd0, depth}, 32'd0);
        ctl("unf_after", 1'b1, 1'b1, 1'b0);
        cyc(1'b0, OP_NOP, 16'd0);
        chk("unf_after_depth", {29'd0, depth}, 32'd1);
        chk("unf_after_qtop",  {16'd0, qtop}, 32'd9);

        // ---------------- DIV / MOD ----------------
        do_reset();
`ifdef STACK_CTRL_DIV_EN
        cyc(1'b1, OP_PUSHI, 16'd17);
        cyc(1'b1, OP_PUSHI, 16'd5);
        cyc(1'b1, OP_MOD, 16'd0);
        ctl("mod_acc", 1'b0, 1'b0, 1'b0);
        wait_iter("mod", 16'd2);
        cyc(1'b1, OP_PUSHI, 16'd0);
        chk("mod_qtop",  {16'd0, qtop}, 32'd2);
        chk("mod_depth", {29'd0, depth}, 32'd1);
        cyc(1'b1, OP_DIV, 16'd0);
        ctl("dz", 1'b0, 1'b0, 1'b0);
        cyc(1'b1, OP_PUSHI, 16'd7);
        chk("dz_err",   {31'd0, err}, 32'd1);
        chk("dz_code",  {30'd0, err_code}, 32'd3);
        chk("dz_depth", {29'd0, depth}, 32'd2);
        // 100 / 7 = 14
        do_reset();
        cyc(1'b1, OP_PUSHI, 16'd100);
        cyc(1'b1, OP_PUSHI, 16'd7);
        cyc(1'b1, OP_DIV, 16'd0);
        wait_iter("div", 16'd14);
        cyc(1'b0, OP_NOP, 16'd0);
        chk("div_qtop", {16'd0, qtop}, 32'd14);
        chk("div_err",  {31'd0, err}, 32'd0);
`else
        cyc(1'b1, OP_PUSHI, 16'd17);
        cyc(1'b1, OP_PUSHI, 16'd5);
        cyc(1'b1, OP_DIV, 16'd0);
        chk("div_ill_ready", {31'd0, ready}, 32'd1);
        ctl("div_ill", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, OP_NOP, 16'd0);
        chk("div_ill_busy",  {31'd0, busy}, 32'd0);
        chk("div_ill_err",   {31'd0, err}, 32'd1);
        chk("div_ill_code",  {30'd0, err_code}, 32'd3);
        chk("div_ill_depth", {29'd0, depth}, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
